mem_arbiter: RTL and testbench

Sequencer and arbiter for the single unified 16-bit memory shared by the instruction cache and the data cache. It grants the memory to one cache at a time, issues the 8-word block-fill read burst or a single write-through store, and tracks the pipelined fixed-latency read return so each fill word reaches the cache with its word index. It sits between the two cache controllers and the memory model, below the pipeline's stall logic.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_ret_tracker.sv | 51 +++++
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants and state encoding for the unified-memory
// arbiter and its read-return tracker.
package mem_arbiter_pkg;

    // Words per cache block (power of two) and the index width that addresses them.
    localparam int BLOCK_WORDS = 8;
    localparam int WORD_IDX_W  = $clog2(BLOCK_WORDS);

    // Byte-offset bits inside a block of 16-bit words; cleared to get the fill base.
    localparam int BLOCK_OFF_MASK = BLOCK_WORDS * 2 - 1;

    // Issue counter needs one extra bit so it can reach BLOCK_WORDS ("all issued").
    localparam int ISSUE_CNT_W = WORD_IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_I_FILL  = 2'd1,
        ST_D_FILL  = 2'd2,
        ST_D_WRITE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_ret_tracker.sv
// mem_ret_tracker: LAT-deep shift register carrying an issue-valid bit and a
// word index alongside a pipelined fixed-latency memory, so the returning data
// can be tagged. Asynchronous clear drops everything in flight.
module mem_ret_tracker #(
    parameter int LAT   = 4,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [IDX_W-1:0] issue_idx,
    output logic             ret_valid,
    output logic [IDX_W-1:0] ret_idx
);

    logic [LAT-1:0] vld_q;
    logic [LAT-1:0] vld_d;
    logic [IDX_W-1:0] idx_q [LAT];
    logic [IDX_W-1:0] idx_d [LAT];

    // Shift every stage one place towards the output; stage 0 takes the new issue.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = issue_valid;
        idx_d[0] = issue_idx;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
    end

    // Stage registers; reset empties the pipe so no stale return is reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < LAT; i++) begin
                idx_q[i] <= idx_d[i];
            end
        end
    end

    // The last stage lines up with the cycle in which mem_rdata is valid.
    assign ret_valid = vld_q[LAT-1];
    assign ret_idx   = idx_q[LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the shared 16-bit memory to the I-cache or D-cache,
// issues 8-word block-fill bursts or single write-through stores, and tags the
// fixed-latency read return with its word index.
// Build option: define MEM_ARB_RR_EN for round-robin on simultaneous requests;
// otherwise the D-cache always wins a tie.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  icache_req,
    input  logic [ADDR_W-1:0]     icache_addr,
    input  logic                  dcache_req,
    input  logic                  dcache_we,
    input  logic [ADDR_W-1:0]     dcache_addr,
    input  logic [DATA_W-1:0]     dcache_wdata,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [DATA_W-1:0]     fill_data,
    output logic                  fill_valid,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic                  fill_to_d,
    output logic                  icache_done,
    output logic                  dcache_done
);

    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(BLOCK_OFF_MASK);

    arb_state_e             state_q,     state_d;
    logic [ISSUE_CNT_W-1:0] cnt_q,       cnt_d;
    logic [ADDR_W-1:0]      base_q,      base_d;
    logic                   to_d_q,      to_d_d;
    logic                   mem_en_q,    mem_en_d;
    logic                   mem_wr_q,    mem_wr_d;
    logic [ADDR_W-1:0]      mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic [WORD_IDX_W-1:0]  mem_idx_q,   mem_idx_d;

    logic                   pick_d;
    logic                   in_fill;
    logic                   ret_valid;
    logic [WORD_IDX_W-1:0]  ret_idx;
    logic                   fill_last;

`ifdef MEM_ARB_RR_EN
    // Last-winner flag (1 = D). It resets to the D side so that the first tie
    // after reset goes to the I-cache.
    logic last_d_q, last_d_d;

    // On a tie, grant whichever cache did not win last time.
    always_comb begin
        pick_d   = dcache_req && (!icache_req || !last_d_q);
        last_d_d = last_d_q;
        if (state_q == ST_IDLE && (icache_req || dcache_req)) begin
            last_d_d = pick_d;
        end
    end

    // Last-winner register, updated at each grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b1;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    // Fixed priority: a pending D request always beats the I-cache.
    always_comb begin
        pick_d = dcache_req;
    end
`endif

    assign in_fill   = (state_q == ST_I_FILL) || (state_q == ST_D_FILL);
    assign fill_last = in_fill && ret_valid && (ret_idx == WORD_IDX_W'(BLOCK_WORDS - 1));

    // Next-state and next-output logic; memory-side outputs are registered so the
    // memory sees a clean, glitch-free command each cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        to_d_d      = to_d_q;
        mem_en_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_idx_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_d && dcache_we) begin
                    // Single store: issue it in the very next cycle.
                    state_d     = ST_D_WRITE;
                    mem_en_d    = 1'b1;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = dcache_addr;
                    mem_wdata_d = dcache_wdata;
                end else if (pick_d || icache_req) begin
                    // Block fill: latch the base and issue word 0 next cycle.
                    state_d    = pick_d ? ST_D_FILL : ST_I_FILL;
                    to_d_d     = pick_d;
                    base_d     = (pick_d ? dcache_addr : icache_addr) & BASE_MASK;
                    mem_en_d   = 1'b1;
                    mem_addr_d = (pick_d ? dcache_addr : icache_addr) & BASE_MASK;
                    mem_idx_d  = '0;
                    cnt_d      = ISSUE_CNT_W'(1);
                end
            end
            ST_I_FILL, ST_D_FILL: begin
                if (cnt_q < ISSUE_CNT_W'(BLOCK_WORDS)) begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = base_q + ADDR_W'({cnt_q, 1'b0});
                    mem_idx_d  = cnt_q[WORD_IDX_W-1:0];
                    cnt_d      = cnt_q + ISSUE_CNT_W'(1);
                end
                if (fill_last) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_D_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state and registered memory command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            to_d_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            to_d_q      <= to_d_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_idx_q   <= mem_idx_d;
        end
    end

    // Only reads enter the return pipe, so stores never raise fill_valid.
    mem_ret_tracker #(
        .LAT   (MEM_LAT),
        .IDX_W (WORD_IDX_W)
    ) u_ret_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (mem_en_q && !mem_wr_q),
        .issue_idx   (mem_idx_q),
        .ret_valid   (ret_valid),
        .ret_idx     (ret_idx)
    );

    assign mem_en      = mem_en_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign fill_data   = mem_rdata;
    assign fill_valid  = ret_valid;
    assign fill_word   = ret_idx;
    assign fill_to_d   = to_d_q;
    assign icache_done = fill_last && (state_q == ST_I_FILL);
    assign dcache_done = (fill_last && (state_q == ST_D_FILL)) || (state_q == ST_D_WRITE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed test of mem_arbiter (default build, fixed priority).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icache_req;
    logic [15:0] icache_addr;
    logic        dcache_req;
    logic        dcache_we;
    logic [15:0] dcache_addr;
    logic [15:0] dcache_wdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] fill_data;
    logic        fill_valid;
    logic [2:0]  fill_word;
    logic        fill_to_d;
    logic        icache_done;
    logic        dcache_done;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .icache_req   (icache_req),
        .icache_addr  (icache_addr),
        .dcache_req   (dcache_req),
        .dcache_we    (dcache_we),
        .dcache_addr  (dcache_addr),
        .dcache_wdata (dcache_wdata),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .fill_data    (fill_data),
        .fill_valid   (fill_valid),
        .fill_word    (fill_word),
        .fill_to_d    (fill_to_d),
        .icache_done  (icache_done),
        .dcache_done  (dcache_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Walks cycles T+1..T+13 of a fill whose request the caller raised in cycle T.
    task automatic run_fill(input bit is_d, input logic [15:0] addr, input bit hold,
                            input int raise_c, input logic [15:0] raise_addr);
        logic [15:0] base;
        base = addr & 16'hFFF0;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            mem_rdata = 16'hC000 | 16'(c);
            #1;
            chk($sformatf("%s c%0d mem_en", is_d ? "D" : "I", c), 32'(mem_en), 32'(c <= 8));
            chk($sformatf("%s c%0d mem_wr", is_d ? "D" : "I", c), 32'(mem_wr), 32'(0));
            if (c <= 8)
                chk($sformatf("%s c%0d mem_addr", is_d ? "D" : "I", c), 32'(mem_addr),
                    32'(base + 16'(2 * (c - 1))));
            chk($sformatf("%s c%0d fill_valid", is_d ? "D" : "I", c), 32'(fill_valid),
                32'(c >= 5 && c <= 12));
            if (c >= 5 && c <= 12) begin
                chk($sformatf("%s c%0d fill_word", is_d ? "D" : "I", c), 32'(fill_word), 32'(c - 5));
                chk($sformatf("%s c%0d fill_to_d", is_d ? "D" : "I", c), 32'(fill_to_d), 32'(is_d));
                chk($sformatf("%s c%0d fill_data", is_d ? "D" : "I", c), 32'(fill_data),
                    32'(16'hC000 | 16'(c)));
            end
            chk($sformatf("%s c%0d icache_done", is_d ? "D" : "I", c), 32'(icache_done),
                32'(c == 12 && !is_d));
            chk($sformatf("%s c%0d dcache_done", is_d ? "D" : "I", c), 32'(dcache_done),
                32'(c == 12 && is_d));
            if (c == raise_c) begin
                dcache_req  = 1'b1;
                dcache_we   = 1'b0;
                dcache_addr = raise_addr;
            end
            if (c == 12 && !hold) begin
                if (is_d) dcache_req = 1'b0;
                else      icache_req = 1'b0;
            end
        end
        $display("txn %s-fill addr=%h base=%h done", is_d ? "D" : "I", addr, base);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " mem_en"},      32'(mem_en),      32'(0));
        chk({tag, " mem_wr"},      32'(mem_wr),      32'(0));
        chk({tag, " mem_addr"},    32'(mem_addr),    32'(0));
        chk({tag, " mem_wdata"},   32'(mem_wdata),   32'(0));
        chk({tag, " fill_valid"},  32'(fill_valid),  32'(0));
        chk({tag, " fill_word"},   32'(fill_word),   32'(0));
        chk({tag, " fill_to_d"},   32'(fill_to_d),   32'(0));
        chk({tag, " icache_done"}, 32'(icache_done), 32'(0));
        chk({tag, " dcache_done"}, 32'(dcache_done), 32'(0));
    endtask

    initial begin
        rst_n        = 1'b0;
        icache_req   = 1'b0;
        icache_addr  = '0;
        dcache_req   = 1'b0;
        dcache_we    = 1'b0;
        dcache_addr  = '0;
        dcache_wdata = '0;
        mem_rdata    = 16'h5A5A;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset fill_data", 32'(fill_data), 32'(16'h5A5A));
        $display("txn reset checked");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // I-miss only.
        icache_req  = 1'b1;
        icache_addr = 16'h1236;
        run_fill(1'b0, 16'h1236, 1'b0, 0, 16'h0);

        // D write.
        @(negedge clk);
        dcache_req   = 1'b1;
        dcache_we    = 1'b1;
        dcache_addr  = 16'h0040;
        dcache_wdata = 16'hBEEF;
        @(negedge clk);
        #1;
        chk("wr mem_en",      32'(mem_en),      32'(1));
        chk("wr mem_wr",      32'(mem_wr),      32'(1));
        chk("wr mem_addr",    32'(mem_addr),    32'(16'h0040));
        chk("wr mem_wdata",   32'(mem_wdata),   32'(16'hBEEF));
        chk("wr dcache_done", 32'(dcache_done), 32'(1));
        chk("wr icache_done", 32'(icache_done), 32'(0));
        chk("wr fill_valid",  32'(fill_valid),  32'(0));
        dcache_req = 1'b0;
        dcache_we  = 1'b0;
        for (int c = 2; c <= 7; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("wr c%0d mem_en", c),      32'(mem_en),      32'(0));
            chk($sformatf("wr c%0d fill_valid", c),  32'(fill_valid),  32'(0));
            chk($sformatf("wr c%0d dcache_done", c), 32'(dcache_done), 32'(0));
        end
        $display("txn D-write addr=0040 data=beef done");

        // Both requests in the same cycle: D first, then I straight after.
        @(negedge clk);
        icache_req  = 1'b1;
        icache_addr = 16'h3008;
        dcache_req  = 1'b1;
        dcache_we   = 1'b0;
        dcache_addr = 16'h2004;
        run_fill(1'b1, 16'h2004, 1'b0, 0, 16'h0);
        run_fill(1'b0, 16'h3008, 1'b0, 0, 16'h0);

        // D request raised mid-fill waits for the I done.
        @(negedge clk);
        icache_req  = 1'b1;
        icache_addr = 16'h1100;
        run_fill(1'b0, 16'h1100, 1'b0, 3, 16'h555A);
        run_fill(1'b1, 16'h555A, 1'b0, 0, 16'h0);

        // Reset in the middle of a D fill.
        @(negedge clk);
        dcache_req  = 1'b1;
        dcache_we   = 1'b0;
        dcache_addr = 16'h0806;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rst c%0d mem_addr", c), 32'(mem_addr), 32'(16'h0800 + 16'(2 * (c - 1))));
        end
        rst_n      = 1'b0;
        dcache_req = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("postrst c%0d fill_valid", c),  32'(fill_valid),  32'(0));
            chk($sformatf("postrst c%0d dcache_done", c), 32'(dcache_done), 32'(0));
            chk($sformatf("postrst c%0d mem_en", c),      32'(mem_en),      32'(0));
        end
        $display("txn reset mid-fill done");
        dcache_req  = 1'b1;
        dcache_addr = 16'h0806;
        run_fill(1'b1, 16'h0806, 1'b0, 0, 16'h0);

        // Back-to-back D fills with the request held through the first done.
        @(negedge clk);
        dcache_req  = 1'b1;
        dcache_we   = 1'b0;
        dcache_addr = 16'h7770;
        run_fill(1'b1, 16'h7770, 1'b1, 0, 16'h0);
        run_fill(1'b1, 16'h7770, 1'b0, 0, 16'h0);

        @(negedge clk);
        #1;
        chk("end mem_en", 32'(mem_en), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
